// File: rtl/gpc_chk_pkg.sv
// Shared types and constants for the gpc3031_5 checker: FSM states, vector and
// sum widths, column weights and a 3-bit population count.
package gpc_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    localparam int VEC_W  = 7;
    localparam int SUM_W  = 5;
    localparam int W_SRC0 = 1;
    localparam int W_SRC1 = 2;
    localparam int W_SRC3 = 8;

    function automatic logic [1:0] popcount3(input logic [2:0] b);
        return {1'b0, b[0]} + {1'b0, b[1]} + {1'b0, b[2]};
    endfunction

endpackage

// File: rtl/gpc3031_5_ref.sv
// Combinational reference model of the (3,0,3,1;5) counter: weighted column
// popcount, at most 31, so it always fits the 5-bit sum.
module gpc3031_5_ref
    import gpc_chk_pkg::*;
(
    input  logic             src0,
    input  logic [2:0]       src1,
    input  logic [2:0]       src3,
    output logic [SUM_W-1:0] exp
);

    assign exp = SUM_W'(W_SRC0 * int'(src0))
               + SUM_W'(W_SRC1 * int'(popcount3(src1)))
               + SUM_W'(W_SRC3 * int'(popcount3(src3)));

endmodule

// File: rtl/gpc3031_5_checker.sv
// Exhaustive sweep checker for an attached gpc3031_5 with LATENCY register stages.
// Optional macro GPC3031_5_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | driving vectors 0x00..0x7F, one per cycle
// DRAIN | LATENCY cycles letting the last results come back
// DONE  | result valid, waiting for start
module gpc3031_5_checker
    import gpc_chk_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             src0,
    output logic [2:0]       src1,
    output logic [2:0]       src3,
    input  logic [SUM_W-1:0] dst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [VEC_W-1:0] fail_vec,
    output logic [SUM_W-1:0] fail_dst
);

    localparam logic [2:0] DRAIN_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    chk_state_t       state, state_nxt;
    logic [VEC_W-1:0] vec, vec_drv, cmp_vec;
    logic [SUM_W-1:0] exp_cur, cmp_exp;
    logic [2:0]       drain_cnt;
    logic             run, start_acc, cmp_valid, cmp_en, mismatch;

    assign run       = (state == ST_RUN);
    assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
    assign vec_drv   = run ? vec : '0;
    assign {src3, src1, src0} = vec_drv;

    gpc3031_5_ref u_ref (
        .src0 (src0),
        .src1 (src1),
        .src3 (src3),
        .exp  (exp_cur)
    );

    if (LATENCY == 0) begin : g_nopipe
        assign cmp_valid = run;
        assign cmp_vec   = vec_drv;
        assign cmp_exp   = exp_cur;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld_q;
        logic [VEC_W-1:0]   vec_q [LATENCY];
        logic [SUM_W-1:0]   exp_q [LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < LATENCY; i++) begin
                    vec_q[i] <= '0;
                    exp_q[i] <= '0;
                end
            end else begin
                for (int i = LATENCY - 1; i > 0; i--) begin
                    vld_q[i] <= vld_q[i-1];
                    vec_q[i] <= vec_q[i-1];
                    exp_q[i] <= exp_q[i-1];
                end
                vld_q[0] <= run;
                vec_q[0] <= vec_drv;
                exp_q[0] <= exp_cur;
                // results still in flight from an aborted sweep must not be scored
                if (start_acc) vld_q <= '0;
            end
        end

        assign cmp_valid = vld_q[LATENCY-1];
        assign cmp_vec   = vec_q[LATENCY-1];
        assign cmp_exp   = exp_q[LATENCY-1];
    end

    assign cmp_en   = cmp_valid && (run || state == ST_DRAIN);
    assign mismatch = cmp_en && (dst != cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (vec == '1) state_nxt = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (drain_cnt == 3'd0) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
`ifdef GPC3031_5_CHK_STOP_ON_FAIL_EN
        if (mismatch) state_nxt = ST_DONE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            drain_cnt <= '0;
            err_cnt   <= '0;
            fail_vec  <= '0;
            fail_dst  <= '0;
        end else if (start_acc) begin
            vec      <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            fail_dst <= '0;
        end else begin
            if (run) vec <= vec + 7'd1;
            if (run && state_nxt == ST_DRAIN) drain_cnt <= DRAIN_INIT;
            else if (state == ST_DRAIN)       drain_cnt <= drain_cnt - 3'd1;
            if (mismatch) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                if (err_cnt == 8'd0) begin
                    fail_vec <= cmp_vec;
                    fail_dst <= dst;
                end
            end
        end
    end

    assign busy = run || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == 8'd0);

endmodule

// File: tb/tb_gpc3031_5_checker.sv
// Bench for gpc3031_5_checker: LATENCY=0 and LATENCY=2 instances against a
// behavioural GPC with an optional dst[3] stuck-at-0 fault.
module tb_gpc3031_5_checker;

    typedef struct {
        bit         fault;
        bit         repulse;
        int         done0;
        int         done2;
        bit         pass;
        int         errc;
        logic [6:0] fvec;
        logic [4:0] fdst;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       fault = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [6:0] sb[$];

    logic       s0_0, s0_2, busy0, busy2, done0, done2, pass0, pass2;
    logic [2:0] s1_0, s3_0, s1_2, s3_2;
    logic [4:0] dst0, dst2, g2_s1, fd0, fd2, fmask;
    logic [7:0] err0, err2;
    logic [6:0] fv0, fv2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] gpc_model(input logic [6:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 7; i++)
            if (v[i]) s += (i == 0) ? 1 : (i < 4) ? 2 : 8;
        return 5'(s);
    endfunction

    assign fmask = fault ? 5'b10111 : 5'b11111;
    assign dst0  = gpc_model({s3_0, s1_0, s0_0}) & fmask;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g2_s1 <= '0;
            dst2  <= '0;
        end else begin
            g2_s1 <= gpc_model({s3_2, s1_2, s0_2});
            dst2  <= g2_s1 & fmask;
        end
    end

    gpc3031_5_checker #(.LATENCY(0)) u_chk0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src0(s0_0), .src1(s1_0), .src3(s3_0), .dst(dst0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_vec(fv0), .fail_dst(fd0)
    );

    gpc3031_5_checker #(.LATENCY(2)) u_chk2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src0(s0_2), .src1(s1_2), .src3(s3_2), .dst(dst2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_vec(fv2), .fail_dst(fd2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: vectors queued at start, popped as the LATENCY=0 checker drives them.
    always @(negedge clk) begin
        if (busy0) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                logic [6:0] e;
                e = sb.pop_front();
                chk("sb_vec", 32'({s3_0, s1_0, s0_0}), 32'(e));
            end
        end
    end

    task automatic load_sb();
        sb.delete();
        for (int i = 0; i < 128; i++) sb.push_back(7'(i));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out0"}, 32'({s0_0, s1_0, s3_0, busy0, done0, pass0, err0, fv0, fd0}), 32'd0);
        chk({tag, "_out2"}, 32'({s0_2, s1_2, s3_2, busy2, done2, pass2, err2, fv2, fd2}), 32'd0);
    endtask

    task automatic do_sweep(input row_t r, input string tag);
        int k, d, got0, got2;
        fault = r.fault;
        load_sb();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = cyc;
        got0 = -1;
        got2 = -1;
        for (int n = 0; n < 400; n++) begin
            d = cyc - k;
            start = r.repulse && (d == 32);
            if (done0 && got0 < 0) got0 = d;
            if (done2 && got2 < 0) got2 = d;
            if (got0 >= 0 && got2 >= 0) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_t0"}, 32'(got0), 32'(r.done0));
        chk({tag, "_done_t2"}, 32'(got2), 32'(r.done2));
        chk({tag, "_busy0"},   32'(busy0), 32'd0);
        chk({tag, "_busy2"},   32'(busy2), 32'd0);
        chk({tag, "_pass0"},   32'(pass0), 32'(r.pass));
        chk({tag, "_pass2"},   32'(pass2), 32'(r.pass));
        chk({tag, "_err0"},    32'(err0),  32'(r.errc));
        chk({tag, "_err2"},    32'(err2),  32'(r.errc));
        chk({tag, "_fvec0"},   32'(fv0),   32'(r.fvec));
        chk({tag, "_fvec2"},   32'(fv2),   32'(r.fvec));
        chk({tag, "_fdst0"},   32'(fd0),   32'(r.fdst));
        chk({tag, "_fdst2"},   32'(fd2),   32'(r.fdst));
    endtask

    initial begin
        row_t rows[3];
        row_t clean;
        int   k;

        clean = '{fault: 1'b0, repulse: 1'b0, done0: 128, done2: 130,
                  pass: 1'b1, errc: 0, fvec: 7'h00, fdst: 5'h00};
        rows[0] = clean;
`ifdef GPC3031_5_CHK_STOP_ON_FAIL_EN
        rows[1] = '{fault: 1'b1, repulse: 1'b0, done0: 17, done2: 19,
                    pass: 1'b0, errc: 1, fvec: 7'h10, fdst: 5'h00};
`else
        rows[1] = '{fault: 1'b1, repulse: 1'b0, done0: 128, done2: 130,
                    pass: 1'b0, errc: 64, fvec: 7'h10, fdst: 5'h00};
`endif
        rows[2] = '{fault: 1'b0, repulse: 1'b1, done0: 128, done2: 130,
                    pass: 1'b1, errc: 0, fvec: 7'h00, fdst: 5'h00};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        for (int i = 0; i < 3; i++) do_sweep(rows[i], $sformatf("row%0d", i));

        // Reset while the sweep is driving vector 0x40.
        fault = 1'b0;
        load_sb();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = cyc;
        for (int n = 0; n < 200 && (cyc - k) != 64; n++) @(negedge clk);
        chk("mid_vec0", 32'({s3_0, s1_0, s0_0}), 32'h40);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        chk_zero("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("postrst");
        do_sweep(clean, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
